addsub_share_arbiter: RTL

//  Shares one AdderSub4bit unit (A,B,M -> Y,Ovrflw) between two requesters.

---
 rtl/addsub_share_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/addsub_share_arbiter.sv
// addsub_share_arbiter
//   Shares one 4-bit add/subtract unit between two requesters. Requests are
//   arbitrated round-robin. The winner's operands are captured, one operation
//   runs, and the result comes back registered with a one-cycle done pulse.
//   A pass through the FSM takes three cycles: IDLE -> EXEC -> DONE -> IDLE.
//
// Ports
//   clk     : clock; all state changes on the rising edge
//   rst     : synchronous active-high reset
//   req     : req[i] is high while requester i wants an operation (level)
//   a0,b0,m0: requester 0 operands and op (m=0 add, m=1 subtract)
//   a1,b1,m1: requester 1 operands and op
//   gnt     : one-hot grant, high during the EXEC cycle
//   done    : one-hot, one-cycle pulse; y/ovf are valid for that requester
//   y, ovf  : result and signed overflow of the last completed operation (held)
//   busy    : high whenever the FSM is not in IDLE
//   op_cnt  : number of completed operations, saturating at all-ones
module addsub_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             m0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             m1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] y,
    output logic             ovf,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic [1:0]       done_reg, done_next;
    logic [WIDTH-1:0] y_reg, y_next;
    logic             ovf_reg, ovf_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             last_reg, last_next;
    logic [WIDTH-1:0] opa_reg, opa_next;
    logic [WIDTH-1:0] opb_reg, opb_next;
    logic             opm_reg, opm_next;
    logic             win;

    // Shared adder/subtractor. It sees only the captured operand registers,
    // so requesters may change their inputs once the grant is seen.
    // Subtraction is A + ~B + 1: B is inverted and M is the carry-in.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;

    assign carry[0] = opm_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            assign b_eff[gi]    = opb_reg[gi] ^ opm_reg;
            assign sum[gi]      = opa_reg[gi] ^ b_eff[gi] ^ carry[gi];
            assign carry[gi+1]  = (opa_reg[gi] & b_eff[gi]) |
                                  (carry[gi] & (opa_reg[gi] ^ b_eff[gi]));
        end
    endgenerate

    // Signed overflow is the carry into the MSB differing from the carry out
    // of it. This covers both add and subtract, because subtract is an add
    // of the inverted operand.
    assign sum_ovf = carry[WIDTH] ^ carry[WIDTH-1];

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        done_next  = done_reg;
        y_next     = y_reg;
        ovf_next   = ovf_reg;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        opm_next   = opm_reg;
        // Winner: the only requester, or on a tie the one that was not served last.
        win        = (req == 2'b11) ? ~last_reg : req[1];

        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    opa_next   = win ? a1 : a0;
                    opb_next   = win ? b1 : b0;
                    opm_next   = win ? m1 : m0;
                    gnt_next   = win ? 2'b10 : 2'b01;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                y_next     = sum;
                ovf_next   = sum_ovf;
                done_next  = gnt_reg;
                gnt_next   = 2'b00;
                last_next  = gnt_reg[1];
                if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                state_next = DONE;
            end
            DONE: begin
                done_next  = 2'b00;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= 2'b00;
            done_reg  <= 2'b00;
            y_reg     <= '0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
            last_reg  <= 1'b1;
            opa_reg   <= '0;
            opb_reg   <= '0;
            opm_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            y_reg     <= y_next;
            ovf_reg   <= ovf_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            opm_reg   <= opm_next;
        end
    end

    assign gnt    = gnt_reg;
    assign done   = done_reg;
    assign y      = y_reg;
    assign ovf    = ovf_reg;
    assign busy   = (state_reg != IDLE);
    assign op_cnt = cnt_reg;

endmodule
